// File: rtl/dp_pkg.sv
// Shared datapath types: output-stage FSM encoding and select-width helper.
// No logic; latency and backpressure are defined by the modules importing it.
package dp_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Select width never drops below one bit, even for degenerate input counts.
  function automatic int clog2_floor1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_sel_n.sv
// Combinational N:1 select, zero data when sel_i is out of range.
// Zero latency, no flow control.
module mux_sel_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (32'(sel_i) == k) data_o = data_i[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pipe_mux_reg.sv
// N:1 select into a registered valid/ready stage with a 2-entry skid; 1-cycle latency,
// o_Ready comes only from registered state. Optional sticky o_SelErr under SELECT_ERR_EN.
module pipe_mux_reg
  import dp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = clog2_floor1(NUM_IN)
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic [NUM_IN*WIDTH-1:0] i_DataIn,
  input  logic [SEL_W-1:0]        i_Select,
  input  logic                    i_Valid,
  output logic                    o_Ready,
  output logic [WIDTH-1:0]        o_DataOut,
  output logic                    o_Valid,
`ifdef SELECT_ERR_EN
  output logic                    o_SelErr,
`endif
  input  logic                    i_Ready
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q;
  logic [WIDTH-1:0] mux_dat;
  logic             accept;
  logic             emit;

  mux_sel_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .data_i (i_DataIn),
    .sel_i  (i_Select),
    .data_o (mux_dat)
  );

  assign accept    = i_Valid & rdy_q;
  assign emit      = (state_q != EMPTY) & i_Ready;
  assign o_Ready   = rdy_q;
  assign o_Valid   = (state_q != EMPTY);
  assign o_DataOut = data_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          data_d  = mux_dat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && !emit) begin
          skid_d  = mux_dat;
          state_d = FULL;
        end else if (accept && emit) begin
          data_d  = mux_dat;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          data_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Ready is registered from the next state so it stays low through reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != FULL);
    end
  end

`ifdef SELECT_ERR_EN
  logic selerr_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      selerr_q <= 1'b0;
    end else if (accept && (32'(i_Select) >= NUM_IN)) begin
      selerr_q <= 1'b1;
    end
  end

  assign o_SelErr = selerr_q;
`endif

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Directed bench for pipe_mux_reg: default 3x32 instance plus a 5x8 instance.
module tb_pipe_mux_reg;

  logic        clk;
  logic        rst_n;

  logic [95:0] din;
  logic [1:0]  sel;
  logic        vld;
  logic        rdy_out;
  logic [31:0] dout;
  logic        vld_out;
  logic        rdy_in;

  logic [39:0] din2;
  logic [2:0]  sel2;
  logic        vld2;
  logic        rdy_out2;
  logic [7:0]  dout2;
  logic        vld_out2;
  logic        rdy_in2;

`ifdef SELECT_ERR_EN
  logic        selerr;
  logic        selerr2;
`endif

  int checks = 0;
  int errors = 0;

  pipe_mux_reg dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_DataIn  (din),
    .i_Select  (sel),
    .i_Valid   (vld),
    .o_Ready   (rdy_out),
    .o_DataOut (dout),
    .o_Valid   (vld_out),
`ifdef SELECT_ERR_EN
    .o_SelErr  (selerr),
`endif
    .i_Ready   (rdy_in)
  );

  pipe_mux_reg #(.WIDTH(8), .NUM_IN(5)) dut2 (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_DataIn  (din2),
    .i_Select  (sel2),
    .i_Valid   (vld2),
    .o_Ready   (rdy_out2),
    .o_DataOut (dout2),
    .o_Valid   (vld_out2),
`ifdef SELECT_ERR_EN
    .o_SelErr  (selerr2),
`endif
    .i_Ready   (rdy_in2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vld = 1'b1; vld2 = 1'b1; rdy_in = 1'b0; rdy_in2 = 1'b0;
    sel = 2'd0; sel2 = 3'd0;
    din = {32'h33, 32'h22, 32'h11};
    din2 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    tick(); tick(); tick();
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", vld_out); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", dout); end
    checks++; if (rdy_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", rdy_out); end
    checks++; if (rdy_out2 !== 1'b0) begin errors++; $display("FAIL reset_ready2: got %b exp 0", rdy_out2); end
    rst_n = 1'b1; vld = 1'b0; vld2 = 1'b0;
    tick();
    checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL release_ready: got %b exp 1", rdy_out); end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL release_valid: got %b exp 0", vld_out); end
    checks++; if (rdy_out2 !== 1'b1) begin errors++; $display("FAIL release_ready2: got %b exp 1", rdy_out2); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp [3];
    exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33;
    din = {32'h33, 32'h22, 32'h11};
    rdy_in = 1'b1; vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      tick();
      checks++; if (dout !== exp[i] || vld_out !== 1'b1) begin errors++; $display("FAIL stream_%0d: got %h/%b exp %h/1", i, dout, vld_out, exp[i]); end
      checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d: got %b exp 1", i, rdy_out); end
    end
    vld = 1'b0;
    tick();
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b exp 0", vld_out); end
  endtask

  task automatic test_back_pressure();
    rdy_in = 1'b0; vld = 1'b1; sel = 2'd0;
    din = {32'h33, 32'h22, 32'hA};
    tick();
    checks++; if (dout !== 32'hA || rdy_out !== 1'b1) begin errors++; $display("FAIL bp_first: got %h/%b exp a/1", dout, rdy_out); end
    din = {32'h33, 32'h22, 32'hB};
    tick();
    checks++; if (rdy_out !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b exp 0", rdy_out); end
    checks++; if (dout !== 32'hA) begin errors++; $display("FAIL bp_full_data: got %h exp a", dout); end
    vld = 1'b0;
    tick();
    checks++; if (dout !== 32'hA || vld_out !== 1'b1) begin errors++; $display("FAIL bp_hold: got %h/%b exp a/1", dout, vld_out); end
    rdy_in = 1'b1;
    tick();
    checks++; if (dout !== 32'hB || vld_out !== 1'b1) begin errors++; $display("FAIL bp_second: got %h/%b exp b/1", dout, vld_out); end
    checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b exp 1", rdy_out); end
    tick();
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", vld_out); end
  endtask

  task automatic test_out_of_range();
    din = {32'h33, 32'h22, 32'h11};
    rdy_in = 1'b1; vld = 1'b1; sel = 2'd3;
    din2 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    rdy_in2 = 1'b1; vld2 = 1'b1; sel2 = 3'd5;
    tick();
    checks++; if (dout !== 32'h0 || vld_out !== 1'b1) begin errors++; $display("FAIL oor_data: got %h/%b exp 0/1", dout, vld_out); end
    checks++; if (dout2 !== 8'h0 || vld_out2 !== 1'b1) begin errors++; $display("FAIL oor_data2: got %h/%b exp 0/1", dout2, vld_out2); end
`ifdef SELECT_ERR_EN
    checks++; if (selerr !== 1'b1) begin errors++; $display("FAIL oor_err: got %b exp 1", selerr); end
`endif
    sel = 2'd1; sel2 = 3'd4;
    tick();
    checks++; if (dout !== 32'h22) begin errors++; $display("FAIL oor_recover: got %h exp 22", dout); end
    checks++; if (dout2 !== 8'h55) begin errors++; $display("FAIL oor_recover2: got %h exp 55", dout2); end
`ifdef SELECT_ERR_EN
    checks++; if (selerr !== 1'b1) begin errors++; $display("FAIL oor_err_sticky: got %b exp 1", selerr); end
`endif
    vld = 1'b0; vld2 = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    rdy_in = 1'b0; vld = 1'b1; sel = 2'd0;
    din = {32'h33, 32'h22, 32'h55};
    tick();
    checks++; if (dout !== 32'h55 || vld_out !== 1'b1) begin errors++; $display("FAIL sim_one: got %h/%b exp 55/1", dout, vld_out); end
    rdy_in = 1'b1;
    din = {32'h33, 32'h22, 32'h66};
    tick();
    checks++; if (dout !== 32'h66 || vld_out !== 1'b1 || rdy_out !== 1'b1) begin errors++; $display("FAIL sim_reload: got %h/%b/%b exp 66/1/1", dout, vld_out, rdy_out); end
    vld = 1'b0; rdy_in = 1'b0;
    tick();
    checks++; if (dout !== 32'h66 || vld_out !== 1'b1) begin errors++; $display("FAIL sim_hold: got %h/%b exp 66/1", dout, vld_out); end
    rdy_in = 1'b1;
    tick();
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL sim_drain: got %b exp 0", vld_out); end
  endtask

  task automatic test_mid_reset();
    rdy_in = 1'b0; vld = 1'b1; sel = 2'd0;
    rdy_in2 = 1'b0; vld2 = 1'b1; sel2 = 3'd4;
    din = {32'h33, 32'h22, 32'h77};
    din2 = {8'hC4, 8'hD3, 8'h33, 8'h22, 8'h11};
    tick();
    checks++; if (dout2 !== 8'hC4) begin errors++; $display("FAIL mr_one2: got %h exp c4", dout2); end
    din = {32'h33, 32'h22, 32'h88};
    sel2 = 3'd3;
    tick();
    checks++; if (rdy_out !== 1'b0 || dout !== 32'h77) begin errors++; $display("FAIL mr_full: got %b/%h exp 0/77", rdy_out, dout); end
    checks++; if (rdy_out2 !== 1'b0 || dout2 !== 8'hC4) begin errors++; $display("FAIL mr_full2: got %b/%h exp 0/c4", rdy_out2, dout2); end
    rst_n = 1'b0; vld = 1'b0; vld2 = 1'b0;
    tick();
    checks++; if (vld_out !== 1'b0 || dout !== 32'h0 || rdy_out !== 1'b0) begin errors++; $display("FAIL mr_reset: got %b/%h/%b exp 0/0/0", vld_out, dout, rdy_out); end
    checks++; if (vld_out2 !== 1'b0 || dout2 !== 8'h0) begin errors++; $display("FAIL mr_reset2: got %b/%h exp 0/0", vld_out2, dout2); end
    rst_n = 1'b1;
    tick();
    rdy_in = 1'b1; rdy_in2 = 1'b1;
    tick();
    checks++; if (vld_out !== 1'b0 || rdy_out !== 1'b1) begin errors++; $display("FAIL mr_no_skid: got %b/%b exp 0/1", vld_out, rdy_out); end
    checks++; if (vld_out2 !== 1'b0 || rdy_out2 !== 1'b1) begin errors++; $display("FAIL mr_no_skid2: got %b/%b exp 0/1", vld_out2, rdy_out2); end
`ifdef SELECT_ERR_EN
    checks++; if (selerr !== 1'b0) begin errors++; $display("FAIL mr_err_clear: got %b exp 0", selerr); end
`endif
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_out_of_range();
    test_simultaneous();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
